lrsm_gen2: RTL and testbench

Parametrised link-layer retry state machine for the CXL controller's retry path. It sits between the flit unpacker (receive CRC and ack status), the packer (sends LLRREQ), and the physical layer (reinit and link-up).
Unlike the fixed six-idle-state generation, it owns these internally:
- the retry timeout counter
- the consecutive-ack counter, qualified per received flit
- the NUM_RETRY and NUM_PHY_REINIT counters, with threshold-driven escalation to PHY_REINIT and ABORT

---
 rtl/lrsm_gen2_pkg.sv | 25 ++
 rtl/lrsm_timeout_cnt.sv | 42 ++++
 rtl/lrsm_gen2.sv | 158 +++++++++++++++
 tb/tb_lrsm_gen2.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrsm_gen2_pkg.sv
// Shared types and defaults for the gen2 link-layer retry state machine.
// No logic: enum encoding, default parameters and a width helper.
package lrsm_gen2_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL     = 3'd0,
    ST_LLRREQ     = 3'd1,
    ST_LOCAL_IDLE = 3'd2,
    ST_PHY_REINIT = 3'd3,
    ST_ABORT      = 3'd4
  } lrsm_state_e;

  localparam int DEF_ACK_SEQ_NUM        = 6;
  localparam int DEF_TIMEOUT_W          = 16;
  localparam int DEF_TIMEOUT_VAL        = 1024;
  localparam int DEF_CNT_W              = 5;
  localparam int DEF_MAX_NUM_RETRY      = 4;
  localparam int DEF_MAX_NUM_PHY_REINIT = 3;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int lrsm_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lrsm_timeout_cnt.sv
// LOCAL_IDLE timeout counter; o_hit is registered and high while the count sits at TIMEOUT_VAL-1.
// Latency: one cycle from count update to flag; no backpressure, clear has priority over enable.
module lrsm_timeout_cnt #(
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_VAL = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_hit
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_VAL - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 hit_q, hit_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
    // Flag tracks the next count so it lines up with the cycle the count reaches the limit.
    hit_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign o_hit = hit_q;

endmodule

// File: rtl/lrsm_gen2.sv
// Link-layer retry state machine: owns retry timeout, consecutive-ack, NUM_RETRY and NUM_PHY_REINIT counters.
// Latency: every transition lands on the next i_clk edge; o_send_req holds until the packer returns i_req_sent.
module lrsm_gen2
  import lrsm_gen2_pkg::*;
#(
  parameter int ACK_SEQ_NUM        = DEF_ACK_SEQ_NUM,
  parameter int TIMEOUT_W          = DEF_TIMEOUT_W,
  parameter int TIMEOUT_VAL        = DEF_TIMEOUT_VAL,
  parameter int CNT_W              = DEF_CNT_W,
  parameter int MAX_NUM_RETRY      = DEF_MAX_NUM_RETRY,
  parameter int MAX_NUM_PHY_REINIT = DEF_MAX_NUM_PHY_REINIT
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_init_done,
  input  logic                                  i_rx_valid,
  input  logic                                  i_rx_crc_ok,
  input  logic                                  i_ack_seq,
  input  logic                                  i_num_retry_match,
  input  logic                                  i_req_sent,
  input  logic                                  i_pl_lnk_up,
  input  logic                                  i_phy_reinit,
  input  logic                                  i_phy_reset,
  output logic                                  o_send_req,
  output logic                                  o_phy_reinit_req,
  output logic                                  o_link_failure,
  output logic                                  o_retry_exit,
  output logic [2:0]                            o_state,
  output logic [CNT_W-1:0]                      o_num_retry,
  output logic [CNT_W-1:0]                      o_num_phy_reinit,
  output logic [lrsm_cnt_w(ACK_SEQ_NUM)-1:0]    o_ack_cnt
);

  localparam int                ACK_W      = lrsm_cnt_w(ACK_SEQ_NUM);
  localparam logic [ACK_W-1:0]  ACK_LAST   = ACK_W'(ACK_SEQ_NUM - 1);
  localparam logic [CNT_W-1:0]  RETRY_MAX  = CNT_W'(MAX_NUM_RETRY);
  localparam logic [CNT_W-1:0]  REINIT_MAX = CNT_W'(MAX_NUM_PHY_REINIT);
  localparam logic [CNT_W-1:0]  CNT_SAT    = '1;

  lrsm_state_e       state_q, state_d;
  logic [CNT_W-1:0]  num_retry_q, num_retry_d;
  logic [CNT_W-1:0]  num_phy_reinit_q, num_phy_reinit_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic              retry_exit_q, retry_exit_d;

  logic phy_evt;
  logic tmo_en;
  logic tmo_hit;

  // ABORT is terminal: PHY events cannot pull the machine out of it.
  assign phy_evt = (i_phy_reinit || i_phy_reset) && (state_q != ST_ABORT);
  assign tmo_en  = (state_q == ST_LOCAL_IDLE);

  lrsm_timeout_cnt #(
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_VAL (TIMEOUT_VAL)
  ) u_tmo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (tmo_en),
    .i_clr (!tmo_en),
    .o_hit (tmo_hit)
  );

  always_comb begin
    state_d          = state_q;
    num_retry_d      = num_retry_q;
    num_phy_reinit_d = num_phy_reinit_q;
    ack_cnt_d        = ack_cnt_q;
    retry_exit_d     = 1'b0;

    if (phy_evt) begin
      state_d   = ST_PHY_REINIT;
      ack_cnt_d = '0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if ((i_rx_valid && !i_rx_crc_ok) || i_init_done) begin
            state_d = ST_LLRREQ;
          end
        end
        ST_LLRREQ: begin
          if (i_req_sent) begin
            if (num_retry_q < RETRY_MAX) begin
              state_d     = ST_LOCAL_IDLE;
              num_retry_d = (num_retry_q == CNT_SAT) ? num_retry_q : num_retry_q + CNT_W'(1);
              ack_cnt_d   = '0;
            end else if (num_phy_reinit_q < REINIT_MAX) begin
              state_d          = ST_PHY_REINIT;
              num_phy_reinit_d = (num_phy_reinit_q == CNT_SAT) ? num_phy_reinit_q
                                                               : num_phy_reinit_q + CNT_W'(1);
            end else begin
              state_d = ST_ABORT;
            end
          end
        end
        ST_LOCAL_IDLE: begin
          // A timeout swallows any ack arriving in the same cycle.
          if (tmo_hit) begin
            state_d = ST_LLRREQ;
          end else if (i_rx_valid) begin
            if (!i_ack_seq) begin
              ack_cnt_d = '0;
            end else if (ack_cnt_q < ACK_LAST) begin
              ack_cnt_d = ack_cnt_q + ACK_W'(1);
            end else if (i_num_retry_match) begin
              state_d          = ST_NORMAL;
              num_retry_d      = '0;
              num_phy_reinit_d = '0;
              ack_cnt_d        = '0;
              retry_exit_d     = 1'b1;
            end else begin
              ack_cnt_d = ACK_LAST;
            end
          end
        end
        ST_PHY_REINIT: begin
          if (i_pl_lnk_up) begin
            state_d     = ST_LLRREQ;
            num_retry_d = '0;
          end
        end
        ST_ABORT: begin
          state_d = ST_ABORT;
        end
        default: begin
          state_d = ST_NORMAL;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= ST_NORMAL;
      num_retry_q      <= '0;
      num_phy_reinit_q <= '0;
      ack_cnt_q        <= '0;
      retry_exit_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      num_retry_q      <= num_retry_d;
      num_phy_reinit_q <= num_phy_reinit_d;
      ack_cnt_q        <= ack_cnt_d;
      retry_exit_q     <= retry_exit_d;
    end
  end

  assign o_send_req       = (state_q == ST_LLRREQ);
  assign o_phy_reinit_req = (state_q == ST_PHY_REINIT);
  assign o_link_failure   = (state_q == ST_ABORT);
  assign o_retry_exit     = retry_exit_q;
  assign o_state          = state_q;
  assign o_num_retry      = num_retry_q;
  assign o_num_phy_reinit = num_phy_reinit_q;
  assign o_ack_cnt        = ack_cnt_q;

endmodule

// File: tb/tb_lrsm_gen2.sv
// Scoreboard bench for lrsm_gen2: a driver feeds directed then random flits into a rule-level model
// and queues the expected outputs; a monitor pops and compares them after every clock edge.
module tb_lrsm_gen2;

  localparam int ACK_N  = 6;
  localparam int TMO    = 16;
  localparam int MAXR   = 2;
  localparam int MAXP   = 1;
  localparam int CNT_W  = 5;
  localparam int ACK_W  = 3;

  localparam int S_NORMAL = 0, S_LLRREQ = 1, S_IDLE = 2, S_REINIT = 3, S_ABORT = 4;

  typedef struct packed {
    logic init_done, rx_valid, crc_ok, ack_seq, match, req_sent, lnk_up, phy_reinit, phy_reset;
  } in_t;

  typedef struct packed {
    logic [2:0]       st;
    logic             send;
    logic             phyreq;
    logic             fail;
    logic             exit;
    logic [CNT_W-1:0] retry;
    logic [CNT_W-1:0] phy;
    logic [ACK_W-1:0] ack;
  } out_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_init_done = 0, i_rx_valid = 0, i_rx_crc_ok = 0, i_ack_seq = 0, i_num_retry_match = 0;
  logic i_req_sent = 0, i_pl_lnk_up = 0, i_phy_reinit = 0, i_phy_reset = 0;
  logic o_send_req, o_phy_reinit_req, o_link_failure, o_retry_exit;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_num_retry, o_num_phy_reinit;
  logic [ACK_W-1:0] o_ack_cnt;

  always #5 i_clk = ~i_clk;

  lrsm_gen2 #(
    .ACK_SEQ_NUM(ACK_N), .TIMEOUT_W(16), .TIMEOUT_VAL(TMO), .CNT_W(CNT_W),
    .MAX_NUM_RETRY(MAXR), .MAX_NUM_PHY_REINIT(MAXP)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_init_done(i_init_done), .i_rx_valid(i_rx_valid),
    .i_rx_crc_ok(i_rx_crc_ok), .i_ack_seq(i_ack_seq), .i_num_retry_match(i_num_retry_match),
    .i_req_sent(i_req_sent), .i_pl_lnk_up(i_pl_lnk_up), .i_phy_reinit(i_phy_reinit),
    .i_phy_reset(i_phy_reset), .o_send_req(o_send_req), .o_phy_reinit_req(o_phy_reinit_req),
    .o_link_failure(o_link_failure), .o_retry_exit(o_retry_exit), .o_state(o_state),
    .o_num_retry(o_num_retry), .o_num_phy_reinit(o_num_phy_reinit), .o_ack_cnt(o_ack_cnt)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   exits_seen = 0;
  out_t exp_q[$];

  // Rule-level model state: cycles spent in LOCAL_IDLE instead of a counter register.
  int m_state = S_NORMAL, m_retry = 0, m_phy = 0, m_ack = 0, m_idle = 0;
  bit m_exit = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic out_t dut_out();
    out_t o;
    o = '{st: o_state, send: o_send_req, phyreq: o_phy_reinit_req, fail: o_link_failure,
          exit: o_retry_exit, retry: o_num_retry, phy: o_num_phy_reinit, ack: o_ack_cnt};
    return o;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.st     = 3'(m_state);
    o.send   = (m_state == S_LLRREQ);
    o.phyreq = (m_state == S_REINIT);
    o.fail   = (m_state == S_ABORT);
    o.exit   = m_exit;
    o.retry  = CNT_W'(m_retry);
    o.phy    = CNT_W'(m_phy);
    o.ack    = ACK_W'(m_ack);
    return o;
  endfunction

  task automatic model_reset();
    m_state = S_NORMAL; m_retry = 0; m_phy = 0; m_ack = 0; m_idle = 0; m_exit = 0;
  endtask

  task automatic model_step(input in_t v);
    m_exit = 0;
    if ((v.phy_reinit || v.phy_reset) && m_state != S_ABORT) begin
      m_state = S_REINIT; m_ack = 0; m_idle = 0;
    end else if (m_state == S_NORMAL) begin
      if ((v.rx_valid && !v.crc_ok) || v.init_done) m_state = S_LLRREQ;
    end else if (m_state == S_LLRREQ) begin
      if (v.req_sent) begin
        if (m_retry < MAXR) begin
          m_state = S_IDLE; m_retry++; m_idle = 0; m_ack = 0;
        end else if (m_phy < MAXP) begin
          m_state = S_REINIT; m_phy++;
        end else begin
          m_state = S_ABORT;
        end
      end
    end else if (m_state == S_IDLE) begin
      if (m_idle == TMO - 1) m_state = S_LLRREQ;
      else if (v.rx_valid) begin
        if (!v.ack_seq) m_ack = 0;
        else if (m_ack + 1 < ACK_N) m_ack++;
        else if (v.match) begin
          m_state = S_NORMAL; m_retry = 0; m_phy = 0; m_ack = 0; m_exit = 1;
        end
      end
      m_idle++;
    end else if (m_state == S_REINIT) begin
      if (v.lnk_up) begin m_state = S_LLRREQ; m_retry = 0; end
    end
  endtask

  task automatic apply(input in_t v);
    i_init_done = v.init_done; i_rx_valid = v.rx_valid; i_rx_crc_ok = v.crc_ok;
    i_ack_seq = v.ack_seq; i_num_retry_match = v.match; i_req_sent = v.req_sent;
    i_pl_lnk_up = v.lnk_up; i_phy_reinit = v.phy_reinit; i_phy_reset = v.phy_reset;
  endtask

  task automatic step(input in_t v);
    @(negedge i_clk);
    apply(v);
    model_step(v);
    exp_q.push_back(model_out());
  endtask

  task automatic settle();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    apply('0);
    i_rst = 1'b1;
    #1;
    chk("reset_outputs", 32'(dut_out()), 32'd0);
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  function automatic in_t f_idle();
    in_t v = '0; v.crc_ok = 1; return v;
  endfunction
  function automatic in_t f_ack();
    in_t v = f_idle(); v.rx_valid = 1; v.ack_seq = 1; v.match = 1; return v;
  endfunction
  function automatic in_t f_nack();
    in_t v = f_idle(); v.rx_valid = 1; return v;
  endfunction
  function automatic in_t f_init();
    in_t v = f_idle(); v.init_done = 1; return v;
  endfunction
  function automatic in_t f_sent();
    in_t v = f_idle(); v.req_sent = 1; return v;
  endfunction
  function automatic in_t f_lnk();
    in_t v = f_idle(); v.lnk_up = 1; return v;
  endfunction

  // Monitor: compares every post-edge output against the queued expectation.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (o_retry_exit === 1'b1) exits_seen++;
      if (exp_q.size() > 0) chk("cycle_outputs", 32'(dut_out()), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int ex0;
    in_t v;
    repeat (3) @(negedge i_clk);
    chk("por_outputs", 32'(dut_out()), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // 1: init, send after 3 cycles, 6 matched acks with 2 idle gaps
    step(f_init()); step(f_idle()); step(f_idle()); step(f_sent());
    settle();
    chk("t1_idle_state", o_state, S_IDLE);
    chk("t1_retry_1", o_num_retry, 1);
    ex0 = exits_seen;
    step(f_ack()); step(f_ack()); step(f_idle()); step(f_ack());
    step(f_ack()); step(f_idle()); step(f_ack()); step(f_ack());
    settle();
    chk("t1_normal", o_state, S_NORMAL);
    chk("t1_retry_0", o_num_retry, 0);
    step(f_idle()); settle();
    chk("t1_exit_pulses", exits_seen - ex0, 1);

    // 2: bad CRC, 4 acks, a non-ack, then 6 acks
    v = f_nack(); v.crc_ok = 0;
    step(v); step(f_sent());
    for (int i = 0; i < 4; i++) step(f_ack());
    settle();
    chk("t2_ack_4", o_ack_cnt, 4);
    step(f_nack()); settle();
    chk("t2_ack_0", o_ack_cnt, 0);
    ex0 = exits_seen;
    for (int i = 0; i < 5; i++) step(f_ack());
    settle();
    chk("t2_no_early_exit", o_state, S_IDLE);
    step(f_ack()); settle();
    chk("t2_exit_normal", o_state, S_NORMAL);
    step(f_idle()); settle();
    chk("t2_exit_pulses", exits_seen - ex0, 1);

    // 3: timeout lands 16 cycles after entry
    step(f_init()); step(f_sent());
    for (int i = 0; i < TMO - 1; i++) step(f_idle());
    settle();
    chk("t3_still_idle", o_state, S_IDLE);
    step(f_idle()); settle();
    chk("t3_timeout", o_state, S_LLRREQ);
    step(f_sent()); settle();
    chk("t3_retry_2", o_num_retry, 2);

    // 4: escalate to PHY_REINIT, recover, then exhaust into ABORT
    for (int i = 0; i < TMO; i++) step(f_idle());
    step(f_sent()); settle();
    chk("t4_reinit", o_state, S_REINIT);
    chk("t4_phy_1", o_num_phy_reinit, 1);
    step(f_lnk()); settle();
    chk("t4_llrreq", o_state, S_LLRREQ);
    chk("t4_retry_0", o_num_retry, 0);
    for (int r = 0; r < MAXR; r++) begin
      step(f_sent());
      for (int i = 0; i < TMO; i++) step(f_idle());
    end
    step(f_sent()); settle();
    chk("t4_abort", o_state, S_ABORT);
    v = f_idle(); v.phy_reset = 1; step(v);
    v = f_idle(); v.phy_reinit = 1; step(v);
    step(f_lnk()); settle();
    chk("t4_sticky_fail", o_link_failure, 1);
    chk("t4_still_abort", o_state, S_ABORT);

    // 5: PHY event beats req_sent; timeout beats the final ack
    do_reset();
    step(f_init());
    v = f_sent(); v.phy_reinit = 1; step(v); settle();
    chk("t5_reinit", o_state, S_REINIT);
    chk("t5_retry_same", o_num_retry, 0);
    step(f_lnk()); step(f_sent());
    ex0 = exits_seen;
    for (int i = 0; i < TMO - ACK_N; i++) step(f_idle());
    for (int i = 0; i < ACK_N; i++) step(f_ack());
    settle();
    chk("t5_timeout_wins", o_state, S_LLRREQ);
    step(f_idle()); settle();
    chk("t5_no_exit", exits_seen - ex0, 0);

    // 6: async reset mid-retry
    do_reset();
    step(f_init()); step(f_sent());
    for (int i = 0; i < 3; i++) step(f_ack());
    settle();
    chk("t6_pre_ack3", o_ack_cnt, 3);
    do_reset();

    // Randomised traffic against the model, with resets to escape ABORT.
    for (int i = 0; i < 4000; i++) begin
      v = '0;
      v.init_done  = ($urandom_range(0, 9) == 0);
      v.rx_valid   = ($urandom_range(0, 2) != 0);
      v.crc_ok     = ($urandom_range(0, 7) != 0);
      v.ack_seq    = ($urandom_range(0, 7) != 0);
      v.match      = ($urandom_range(0, 7) != 0);
      v.req_sent   = ($urandom_range(0, 2) == 0);
      v.lnk_up     = ($urandom_range(0, 3) == 0);
      v.phy_reinit = ($urandom_range(0, 59) == 0);
      v.phy_reset  = ($urandom_range(0, 79) == 0);
      if ((m_state == S_ABORT && $urandom_range(0, 15) == 0) || $urandom_range(0, 999) == 0)
        do_reset();
      else
        step(v);
    end

    repeat (3) @(negedge i_clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
